vga_timing_gen: RTL and testbench

Generates VGA 640x480@60 raster timing: horizontal/vertical pixel counters, active-low sync pulses and the active-video `blank` flag that sprite and palette display blocks consume as `DrawX`, `DrawY` and `blank`. Sprite display blocks look up a synchronous ROM and then register their colour output, adding 2 cycles of latency. This block therefore also provides sync and blank copies delayed by `PIPE_DELAY` cycles to drive the VGA pins in alignment with the colour data. It also emits per-line and per-frame strobes and a frame counter for animation logic.

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, active-low syncs, active-video flag,
// delayed sync/blank copies for pin alignment, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [9:0] HsStart = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Reset image of one delay stage: {hs, vs, blank} with blank low so the pins show black.
  localparam logic [2:0] PipeRst = 3'b110;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       vis_q, vis_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       h_wrap, v_wrap;

  // Next counter values and decode from those, so registered outputs match the new position.
  always_comb begin
    h_wrap = (x_q == HLast);
    v_wrap = (y_q == VLast);

    x_d = h_wrap ? 10'd0 : x_q + 10'd1;
    y_d = y_q;
    if (h_wrap) begin
      y_d = v_wrap ? 10'd0 : y_q + 10'd1;
    end

    hsync_d = !((x_d >= HsStart) && (x_d < HsEnd));
    vsync_d = !((y_d >= VsStart) && (y_d < VsEnd));
    vis_d   = (x_d < HVis) && (y_d < VVis);

    // Strobes only come from a real wrap, never from leaving reset.
    line_d  = h_wrap;
    frame_d = h_wrap && v_wrap;
    fcnt_d  = fcnt_q;
    if (h_wrap && v_wrap) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  // Counter, decode and strobe state.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      vis_q   <= 1'b1;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vis_q   <= vis_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign blank       = vis_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_count = fcnt_q;

  // Delay line for the pin-side copies, matching the colour pipeline latency downstream.
  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign hs_d    = hsync_q;
    assign vs_d    = vsync_q;
    assign blank_d = vis_q;
  end else begin : g_pipe
    localparam int unsigned Last = PIPE_DELAY - 1;

    logic [2:0] pipe_q [PIPE_DELAY];
    logic [2:0] pipe_d [PIPE_DELAY];

    // Shift {hs, vs, blank} one stage per cycle.
    always_comb begin
      pipe_d[0] = {hsync_q, vsync_q, vis_q};
      for (int i = 1; i < int'(PIPE_DELAY); i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Delay stages, all cleared to the black/idle-sync image.
    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= PipeRst;
        end
      end else begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign hs_d    = pipe_q[Last][2];
    assign vs_d    = pipe_q[Last][1];
    assign blank_d = pipe_q[Last][0];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (16x13 totals) so full frames are short.
// Two instances: PIPE_DELAY=2 and PIPE_DELAY=0, sharing clock and reset.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;  // 16
  localparam int VT = VV + VF + VS + VB;  // 13
  localparam int FT = HT * VT;            // 208

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       hs_d;
    logic       vs_d;
    logic       blank_d;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;

  logic [9:0] x2, y2, x0, y0;
  logic       hs2, vs2, bl2, hsd2, vsd2, bld2, ls2, fs2;
  logic       hs0, vs0, bl0, hsd0, vsd0, bld0, ls0, fs0;
  logic [7:0] fc2, fc0;

  int total = 0;
  int bad   = 0;

  obs_t exp_q2[$];
  obs_t exp_q0[$];
  int   t_q[$];

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(2)
  ) u_dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(x2), .DrawY(y2),
    .hs(hs2), .vs(vs2), .blank(bl2), .hs_d(hsd2), .vs_d(vsd2), .blank_d(bld2),
    .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(0)
  ) u_dut0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(x0), .DrawY(y0),
    .hs(hs0), .vs(vs0), .blank(bl0), .hs_d(hsd0), .vs_d(vsd0), .blank_d(bld0),
    .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );

  function automatic obs_t act2();
    act2 = {x2, y2, hs2, vs2, bl2, hsd2, vsd2, bld2, ls2, fs2, fc2};
  endfunction

  function automatic obs_t act0();
    act0 = {x0, y0, hs0, vs0, bl0, hsd0, vsd0, bld0, ls0, fs0, fc0};
  endfunction

  // Undelayed {hs, vs, blank} at t edges after reset release.
  function automatic logic [2:0] und(int t);
    int x;
    int y;
    x = t % HT;
    y = (t / HT) % VT;
    und = {!(x >= HV + HF && x < HV + HF + HS), !(y >= VV + VF && y < VV + VF + VS),
           (x < HV && y < VV)};
  endfunction

  function automatic obs_t model(int t, int pd);
    obs_t o;
    int x;
    int y;
    x = t % HT;
    y = (t / HT) % VT;
    o.x = 10'(x);
    o.y = 10'(y);
    {o.hs, o.vs, o.blank} = und(t);
    if (pd == 0) {o.hs_d, o.vs_d, o.blank_d} = und(t);
    else if (t >= pd) {o.hs_d, o.vs_d, o.blank_d} = und(t - pd);
    else {o.hs_d, o.vs_d, o.blank_d} = 3'b110;
    o.ls = (t > 0) && (x == 0);
    o.fs = (t > 0) && (x == 0) && (y == 0);
    o.fc = 8'((t / FT) % 256);
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a new position; compare against the queued model.
  always @(negedge vga_clk) begin
    if (exp_q2.size() > 0) begin
      obs_t e2;
      obs_t e0;
      int   tt;
      e2 = exp_q2.pop_front();
      e0 = exp_q0.pop_front();
      tt = t_q.pop_front();
      total += 2;
      if (act2() !== e2) begin
        bad++;
        $display("FAIL sb_pd2 t=%0d got=%h want=%h", tt, act2(), e2);
      end
      if (act0() !== e0) begin
        bad++;
        $display("FAIL sb_pd0 t=%0d got=%h want=%h", tt, act0(), e0);
      end
    end
  end

  task automatic push(input int t);
    exp_q2.push_back(model(t, 2));
    exp_q0.push_back(model(t, 0));
    t_q.push_back(t);
  endtask

  localparam int EndT = 257 * FT + 8 * HT + 12;  // (12,8) of frame 257: hs and vs both low

  initial begin
    obs_t rst_exp2;
    obs_t rst_exp0;
    int   ls_cnt, hs_low, bl_cnt, vs_low, bl_vblank, fs_cnt;
    ls_cnt = 0; hs_low = 0; bl_cnt = 0; vs_low = 0; bl_vblank = 0; fs_cnt = 0;
    rst_exp2 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    rst_exp0 = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    repeat (3) @(posedge vga_clk);
    #1;
    chk_obs("reset_pd2", act2(), rst_exp2);
    chk_obs("reset_pd0", act0(), rst_exp0);

    @(negedge vga_clk);
    #2 reset = 1'b0;
    #1;
    chk_obs("release_pd2", act2(), rst_exp2);
    chk("release_blank_d", int'(bld2), 0);

    for (int t = 1; t <= EndT; t++) begin
      @(posedge vga_clk);
      #1;
      push(t);
      if (t <= HT) begin
        ls_cnt += int'(ls2);
        hs_low += int'(!hs2);
        bl_cnt += int'(bl2);
      end
      if (t <= FT) begin
        vs_low += int'(!vs2);
        fs_cnt += int'(fs2);
        if (y2 >= 10'(VV)) bl_vblank += int'(bl2);
      end
      if (t == 1) chk("blank_d_t1", int'(bld2), 0);
      if (t == 2) chk("blank_d_t2", int'(bld2), 1);
      if (t == HT - 1) chk("x_last", int'(x2), HT - 1);
      if (t == HT) begin
        chk("x_wrap", int'(x2), 0);
        chk("y_step", int'(y2), 1);
        chk("line_start_l1", int'(ls2), 1);
      end
      if (t == FT) begin
        chk("frame_start_f1", int'(fs2), 1);
        chk("frame_count_f1", int'(fc2), 1);
      end
      if (t == 256 * FT - 1) chk("frame_count_255", int'(fc2), 255);
      if (t == 256 * FT) begin
        chk("frame_count_wrap", int'(fc2), 0);
        chk("frame_start_wrap", int'(fs2), 1);
      end
    end
    chk("line_start_cnt", ls_cnt, 1);
    chk("hs_low_cycles", hs_low, 3);
    chk("blank_line_cycles", bl_cnt, 8);
    chk("vs_low_cycles", vs_low, 32);
    chk("blank_in_vblank", bl_vblank, 0);
    chk("frame_start_cnt", fs_cnt, 1);

    // Mid-frame asynchronous reset.
    @(negedge vga_clk);
    chk("pre_rst_x", int'(x2), 12);
    chk("pre_rst_y", int'(y2), 8);
    chk("pre_rst_fc", int'(fc2), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_x", int'(x2), 0);
    chk("async_y", int'(y2), 0);
    chk("async_hs", int'(hs2), 1);
    chk("async_vs", int'(vs2), 1);
    chk("async_blank_d", int'(bld2), 0);
    chk("async_fc", int'(fc2), 0);
    chk_obs("async_pd0", act0(), rst_exp0);
    repeat (3) @(posedge vga_clk);
    #1;
    chk_obs("rst_hold_pd2", act2(), rst_exp2);

    @(negedge vga_clk);
    #2 reset = 1'b0;
    #1;
    chk_obs("rerelease_pd2", act2(), rst_exp2);
    chk_obs("rerelease_pd0", act0(), rst_exp0);
    for (int t = 1; t <= HT + 3; t++) begin
      @(posedge vga_clk);
      #1;
      push(t);
    end
    @(negedge vga_clk);
    #1;
    chk("queue_drained", exp_q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
